pmem_line_arbiter: RTL and testbench

- Shares the single physical-memory line port between the instruction cache and the data cache.
- Sits between ICACHE/DCACHE (line side) and the cacheline adaptor that drives the 64-bit pmem bursts.
- Serialises line fills and writebacks, latches the request of the granted requester, and routes the response back to it.
- One transaction is in flight at a time.

---
 rtl/pmem_line_arbiter.sv | 170 +++++++++++++++++
 tb/tb_pmem_line_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_line_arbiter.sv
// pmem_line_arbiter: shares one physical-memory line port between the
// instruction cache and the data cache. One transaction is in flight at a
// time. The winner's request is latched at grant, and the adaptor response is
// routed back to that requester.
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_read          icache line read request (level, held until i_resp)
//   i_address       icache line address
//   i_rdata/i_resp  icache returned line / one-cycle done pulse
//   d_read/d_write  dcache line read / writeback request (both high = write)
//   d_address       dcache line address
//   d_wdata         dcache writeback line
//   d_rdata/d_resp  dcache returned line / one-cycle done pulse
//   m_read/m_write  registered line read / write to the cacheline adaptor
//   m_address       registered line address to the adaptor
//   m_wdata         registered line write data to the adaptor
//   m_rdata/m_resp  adaptor read line / one-cycle done pulse
//
// Build option: define ARB_ROUND_ROBIN_EN to choose the requester not granted
// last on a simultaneous request. When it is undefined, the dcache has fixed
// priority.
module pmem_line_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_address,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_address_q, m_address_d;
  logic [LINE_W-1:0] m_wdata_q, m_wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;
  logic              i_req_c, d_req_c, pick_d_c;

  // Request decode and winner selection.
  always_comb begin
    i_req_c = i_read;
    d_req_c = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
    pick_d_c = d_req_c & (~i_req_c | (last_grant_q == GRANT_I));
`else
    pick_d_c = d_req_c;
`endif
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    m_read_d     = m_read_q;
    m_write_d    = m_write_q;
    m_address_d  = m_address_q;
    m_wdata_d    = m_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_resp_d     = 1'b0;
    d_resp_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_d_c) begin
          // Write wins when the dcache raises both read and write.
          m_address_d  = d_address;
          m_wdata_d    = d_wdata;
          m_write_d    = d_write;
          m_read_d     = ~d_write;
          last_grant_d = GRANT_D;
          state_d      = BUSY_D;
        end else if (i_req_c) begin
          m_address_d  = i_address;
          m_read_d     = 1'b1;
          m_write_d    = 1'b0;
          last_grant_d = GRANT_I;
          state_d      = BUSY_I;
        end
      end
      BUSY_I: begin
        if (m_resp) begin
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          i_rdata_d = m_rdata;
          i_resp_d  = 1'b1;
          state_d   = RESP;
        end
      end
      BUSY_D: begin
        if (m_resp) begin
          // A writeback leaves the returned-line register untouched.
          if (m_read_q) d_rdata_d = m_rdata;
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          d_resp_d  = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        // Requests are not sampled here, so a requester that drops its
        // request on resp is never re-granted.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      m_read_q     <= 1'b0;
      m_write_q    <= 1'b0;
      m_address_q  <= '0;
      m_wdata_q    <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      i_resp_q     <= 1'b0;
      d_resp_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m_read_q     <= m_read_d;
      m_write_q    <= m_write_d;
      m_address_q  <= m_address_d;
      m_wdata_q    <= m_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_resp_q     <= i_resp_d;
      d_resp_q     <= d_resp_d;
    end
  end

  assign m_read    = m_read_q;
  assign m_write   = m_write_q;
  assign m_address = m_address_q;
  assign m_wdata   = m_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_resp    = i_resp_q;
  assign d_resp    = d_resp_q;

endmodule

// File: tb/tb_pmem_line_arbiter.sv
// Directed self-checking bench for pmem_line_arbiter.
module tb_pmem_line_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;

  logic              clk;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_address;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;
  logic              m_resp;

  int checks;
  int errors;

  pmem_line_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_read    (i_read),
    .i_address (i_address),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_address (d_address),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .m_read    (m_read),
    .m_write   (m_write),
    .m_address (m_address),
    .m_wdata   (m_wdata),
    .m_rdata   (m_rdata),
    .m_resp    (m_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; outputs are then stable for sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_read = 1'b0; i_address = '0;
    d_read = 1'b0; d_write = 1'b0; d_address = '0; d_wdata = '0;
    m_rdata = '0;  m_resp = 1'b0;
    #2;
    checks++;
    if ({m_read, m_write, i_resp, d_resp} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {m_read, m_write, i_resp, d_resp});
    end
    checks++;
    if (m_address !== '0 || m_wdata !== '0) begin
      errors++; $display("FAIL reset_m_bus got addr %h wdata %h exp 0", m_address, m_wdata);
    end
    checks++;
    if (i_rdata !== '0 || d_rdata !== '0) begin
      errors++; $display("FAIL reset_rdata got i %h d %h exp 0", i_rdata, d_rdata);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_icache_read();
    logic [LINE_W-1:0] pat;
    pat = {8{32'hDEAD_BEEF}};
    i_read = 1'b1; i_address = 32'h0000_0060;
    tick();
    checks++;
    if (m_read !== 1'b1 || m_write !== 1'b0 || m_address !== 32'h60) begin
      errors++; $display("FAIL i_grant got rd %b wr %b addr %h exp 1 0 60", m_read, m_write, m_address);
    end
    // Adaptor answers 5 cycles after m_read rises; request bus must hold.
    for (int k = 0; k < 4; k++) begin
      i_address = 32'hFFFF_FFFF;
      tick();
      checks++;
      if (m_read !== 1'b1 || m_address !== 32'h60) begin
        errors++; $display("FAIL i_hold cyc %0d got rd %b addr %h exp 1 60", k, m_read, m_address);
      end
    end
    m_resp = 1'b1; m_rdata = pat;
    tick();
    m_resp = 1'b0; m_rdata = '0;
    checks++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== pat || m_read !== 1'b0) begin
      errors++; $display("FAIL i_resp got ir %b dr %b mr %b data %h", i_resp, d_resp, m_read, i_rdata);
    end
    i_read = 1'b0;
    tick();
    checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0 || i_rdata !== pat) begin
      errors++; $display("FAIL i_resp_pulse got ir %b dr %b data %h exp 0 0 held", i_resp, d_resp, i_rdata);
    end
    tick();
  endtask

  task automatic test_dcache_write();
    logic [LINE_W-1:0] wpat;
    wpat = {8{32'h1234_5678}};
    d_write = 1'b1; d_address = 32'h0000_1F80; d_wdata = wpat;
    tick();
    checks++;
    if (m_write !== 1'b1 || m_read !== 1'b0 || m_address !== 32'h1F80 || m_wdata !== wpat) begin
      errors++; $display("FAIL d_wr_grant got wr %b rd %b addr %h wdata %h", m_write, m_read, m_address, m_wdata);
    end
    tick();
    m_resp = 1'b1; m_rdata = {8{32'hBAD0_BAD0}};
    tick();
    m_resp = 1'b0; m_rdata = '0;
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== '0 || m_write !== 1'b0) begin
      errors++; $display("FAIL d_wr_resp got dr %b ir %b mw %b d_rdata %h exp 1 0 0 0", d_resp, i_resp, m_write, d_rdata);
    end
    d_write = 1'b0;
    tick();
    checks++;
    if (d_resp !== 1'b0) begin
      errors++; $display("FAIL d_wr_pulse got %b exp 0", d_resp);
    end
    tick();
  endtask

  task automatic test_simultaneous();
    logic [LINE_W-1:0] da, ia;
    da = {8{32'hAAAA_0001}};
    ia = {8{32'h5555_0002}};
    do_reset();
    i_read = 1'b1; i_address = 32'h40;
    d_read = 1'b1; d_address = 32'h80;
    tick();
    checks++;
    if (m_read !== 1'b1 || m_address !== 32'h80) begin
      errors++; $display("FAIL sim_first got rd %b addr %h exp 1 80", m_read, m_address);
    end
    m_resp = 1'b1; m_rdata = da;
    tick();
    m_resp = 1'b0;
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || d_rdata !== da) begin
      errors++; $display("FAIL sim_d_resp got dr %b ir %b data %h", d_resp, i_resp, d_rdata);
    end
    d_read = 1'b0;
    tick();
    checks++;
    if (m_read !== 1'b0 || d_resp !== 1'b0 || i_resp !== 1'b0) begin
      errors++; $display("FAIL sim_resp_state got mr %b dr %b ir %b exp 0 0 0", m_read, d_resp, i_resp);
    end
    tick();
    checks++;
    if (m_read !== 1'b1 || m_address !== 32'h40) begin
      errors++; $display("FAIL sim_second got rd %b addr %h exp 1 40", m_read, m_address);
    end
    m_resp = 1'b1; m_rdata = ia;
    tick();
    m_resp = 1'b0;
    checks++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== ia || d_rdata !== da) begin
      errors++; $display("FAIL sim_i_resp got ir %b dr %b i %h d %h", i_resp, d_resp, i_rdata, d_rdata);
    end
    i_read = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_arbitration_policy();
    logic exp_last_d;
    logic exp_win_d;
    do_reset();
    exp_last_d = 1'b0;
    i_read = 1'b1; i_address = 32'h100;
    d_read = 1'b1; d_address = 32'h200;
    for (int t = 0; t < 4; t++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_win_d = ~exp_last_d;
`else
      exp_win_d = 1'b1;
`endif
      exp_last_d = exp_win_d;
      tick();
      checks++;
      if (m_read !== 1'b1 || m_address !== (exp_win_d ? 32'h200 : 32'h100)) begin
        errors++; $display("FAIL policy_grant %0d got rd %b addr %h exp_d %b", t, m_read, m_address, exp_win_d);
      end
      m_resp = 1'b1; m_rdata = {8{t[31:0]}};
      tick();
      m_resp = 1'b0;
      checks++;
      if (d_resp !== exp_win_d || i_resp !== ~exp_win_d) begin
        errors++; $display("FAIL policy_resp %0d got dr %b ir %b exp_d %b", t, d_resp, i_resp, exp_win_d);
      end
      tick();
    end
    i_read = 1'b0; d_read = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    logic [LINE_W-1:0] wpat;
    wpat = {8{32'hC0DE_0300}};
    d_write = 1'b1; d_address = 32'h300; d_wdata = wpat;
    tick();
    checks++;
    if (m_write !== 1'b1 || m_address !== 32'h300) begin
      errors++; $display("FAIL mid_grant got wr %b addr %h exp 1 300", m_write, m_address);
    end
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (m_write !== 1'b0 || m_read !== 1'b0 || m_address !== '0) begin
      errors++; $display("FAIL mid_async_drop got wr %b rd %b addr %h exp 0 0 0", m_write, m_read, m_address);
    end
    m_resp = 1'b1;
    tick();
    checks++;
    if (d_resp !== 1'b0) begin
      errors++; $display("FAIL mid_no_resp got %b exp 0", d_resp);
    end
    m_resp = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (m_write !== 1'b1 || m_address !== 32'h300 || m_wdata !== wpat || d_resp !== 1'b0) begin
      errors++; $display("FAIL mid_regrant got wr %b addr %h dr %b", m_write, m_address, d_resp);
    end
    m_resp = 1'b1;
    tick();
    m_resp = 1'b0;
    checks++;
    if (d_resp !== 1'b1) begin
      errors++; $display("FAIL mid_final_resp got %b exp 1", d_resp);
    end
    d_write = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_read_write_both();
    logic [LINE_W-1:0] prev_d;
    prev_d = d_rdata;
    m_resp = 1'b1; m_rdata = {8{32'h0BAD_F00D}};
    tick();
    m_resp = 1'b0;
    checks++;
    if (d_resp !== 1'b0 || i_resp !== 1'b0 || m_read !== 1'b0 || m_write !== 1'b0) begin
      errors++; $display("FAIL stray_resp got dr %b ir %b mr %b mw %b exp 0", d_resp, i_resp, m_read, m_write);
    end
    tick();
    checks++;
    if (d_resp !== 1'b0 || i_resp !== 1'b0) begin
      errors++; $display("FAIL stray_resp_late got dr %b ir %b exp 0 0", d_resp, i_resp);
    end
    d_read = 1'b1; d_write = 1'b1; d_address = 32'h200; d_wdata = {8{32'h7777_0200}};
    tick();
    checks++;
    if (m_write !== 1'b1 || m_read !== 1'b0 || m_address !== 32'h200) begin
      errors++; $display("FAIL rw_as_write got wr %b rd %b addr %h exp 1 0 200", m_write, m_read, m_address);
    end
    m_resp = 1'b1;
    tick();
    m_resp = 1'b0;
    checks++;
    if (d_resp !== 1'b1 || d_rdata !== prev_d) begin
      errors++; $display("FAIL rw_resp got dr %b data %h exp 1 %h", d_resp, d_rdata, prev_d);
    end
    d_read = 1'b0; d_write = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_icache_read();
    test_dcache_write();
    test_simultaneous();
    test_arbitration_policy();
    test_reset_mid();
    test_read_write_both();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
